// File: rtl/sprite_draw_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_draw_scheduler
//  Brief    : Per-frame sprite table walker; swaps frame buffers on vsync and
//             issues one Start/Done draw handshake per valid table entry.
//  Revision : 1.0
// ============================================================================
module sprite_draw_scheduler #(
    parameter int N_SPRITES = 16,
    localparam int AW = $clog2(N_SPRITES)
) (
    input  logic          Clk,
    input  logic          Reset_N,
    input  logic          enable,
    input  logic          vsync,
    input  logic          tbl_we,
    input  logic [AW-1:0] tbl_addr,
    input  logic [23:0]   tbl_wdata,
    output logic          draw_start,
    output logic [2:0]    draw_img_id,
    output logic [9:0]    draw_x,
    output logic [9:0]    draw_y,
    input  logic          draw_done,
    output logic          even_frame,
    output logic          busy,
    output logic [15:0]   frame_count,
    output logic [7:0]    overrun_count
);

    localparam logic [2:0] c_idle    = 3'd0;
    localparam logic [2:0] c_swap    = 3'd1;
    localparam logic [2:0] c_scan    = 3'd2;
    localparam logic [2:0] c_issue   = 3'd3;
    localparam logic [2:0] c_release = 3'd4;
    localparam logic [AW-1:0] c_last = AW'(N_SPRITES - 1);

    logic [2:0]    r_state;
    logic [2:0]    w_next_state;
    logic          r_vsync_q;
    logic          w_edge;
    logic [23:0]   r_table [N_SPRITES];
    logic [AW-1:0] r_index;
    logic [23:0]   w_entry;
    logic          w_last;
    logic          w_busy;
    logic          w_latch;
    logic          w_index_inc;
    logic          w_frame_done;

    logic          r_draw_start;
    logic [2:0]    r_img_id;
    logic [9:0]    r_x;
    logic [9:0]    r_y;
    logic          r_even;
    logic [15:0]   r_frame_count;
    logic [7:0]    r_overrun;

    assign w_edge  = vsync & ~r_vsync_q;
    assign w_entry = r_table[r_index];
    assign w_last  = (r_index == c_last);

    // State register
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:    if (w_edge && enable) w_next_state = c_swap;
            c_swap:    w_next_state = c_scan;
            c_scan: begin
                if (w_entry[23])  w_next_state = c_issue;
                else if (w_last)  w_next_state = c_idle;
            end
            c_issue:   if (draw_done) w_next_state = c_release;
            c_release: begin
                if (!draw_done) w_next_state = w_last ? c_idle : c_scan;
            end
            default:   w_next_state = c_idle;
        endcase
    end

    // Output / control decode
    always_comb begin
        w_busy       = (r_state != c_idle);
        w_latch      = (r_state == c_scan) && w_entry[23];
        w_index_inc  = ((r_state == c_scan) && !w_entry[23] && !w_last) ||
                       ((r_state == c_release) && !draw_done && !w_last);
        w_frame_done = ((r_state == c_scan) && !w_entry[23] && w_last) ||
                       ((r_state == c_release) && !draw_done && w_last);
    end

    // Table and index; a write lands on the next edge, so SCAN sees the old entry
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            for (int i = 0; i < N_SPRITES; i++) begin
                r_table[i] <= 24'd0;
            end
            r_index   <= '0;
            r_vsync_q <= 1'b0;
        end else begin
            if (tbl_we) begin
                r_table[tbl_addr] <= tbl_wdata;
            end
            if (r_state == c_swap) begin
                r_index <= '0;
            end else if (w_index_inc) begin
                r_index <= r_index + AW'(1);
            end
            r_vsync_q <= vsync;
        end
    end

    // Engine command, frame select and counters
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            r_draw_start  <= 1'b0;
            r_img_id      <= 3'd0;
            r_x           <= 10'd0;
            r_y           <= 10'd0;
            r_even        <= 1'b0;
            r_frame_count <= 16'd0;
            r_overrun     <= 8'd0;
        end else begin
            r_draw_start <= (w_next_state == c_issue);
            if (w_latch) begin
                r_img_id <= w_entry[22:20];
                r_y      <= w_entry[19:10];
                r_x      <= w_entry[9:0];
            end
            if (r_state == c_swap) begin
                r_even <= ~r_even;
            end
            if (w_frame_done) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
            if (w_edge && w_busy && (r_overrun != 8'hFF)) begin
                r_overrun <= r_overrun + 8'd1;
            end
        end
    end

    assign draw_start    = r_draw_start;
    assign draw_img_id   = r_img_id;
    assign draw_x        = r_x;
    assign draw_y        = r_y;
    assign even_frame    = r_even;
    assign busy          = w_busy;
    assign frame_count   = r_frame_count;
    assign overrun_count = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sprite_draw_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_draw_scheduler
//  Brief    : Directed bench with engine model and draw-command scoreboard.
//  Revision : 1.0
// ============================================================================
module tb_sprite_draw_scheduler;

    localparam int N = 16;

    logic        Clk = 1'b0;
    logic        Reset_N = 1'b0;
    logic        enable = 1'b0;
    logic        vsync = 1'b0;
    logic        tbl_we = 1'b0;
    logic [3:0]  tbl_addr = 4'd0;
    logic [23:0] tbl_wdata = 24'd0;
    logic        draw_start;
    logic [2:0]  draw_img_id;
    logic [9:0]  draw_x;
    logic [9:0]  draw_y;
    logic        draw_done = 1'b0;
    logic        even_frame;
    logic        busy;
    logic [15:0] frame_count;
    logic [7:0]  overrun_count;

    int tests = 0;
    int fails = 0;
    int hold_cycles = 0;
    int starts = 0;
    int ecnt = 0;
    int starts0;
    int n;
    logic prev_start = 1'b0;
    logic [22:0] sb [$];
    logic [22:0] exp_cmd;
    logic [23:0] shadow [N];

    sprite_draw_scheduler #(.N_SPRITES(N)) dut (
        .Clk(Clk), .Reset_N(Reset_N), .enable(enable), .vsync(vsync),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
        .draw_start(draw_start), .draw_img_id(draw_img_id),
        .draw_x(draw_x), .draw_y(draw_y), .draw_done(draw_done),
        .even_frame(even_frame), .busy(busy),
        .frame_count(frame_count), .overrun_count(overrun_count)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_entry(input int a, input bit v, input int id, input int x, input int y);
        tbl_we    = 1'b1;
        tbl_addr  = a[3:0];
        tbl_wdata = {v, id[2:0], y[9:0], x[9:0]};
        shadow[a] = tbl_wdata;
        @(negedge Clk);
        tbl_we    = 1'b0;
    endtask

    task automatic push_frame();
        for (int i = 0; i < N; i++) begin
            if (shadow[i][23]) sb.push_back(shadow[i][22:0]);
        end
    endtask

    task automatic pulse_vsync();
        vsync = 1'b1;
        @(negedge Clk);
        vsync = 1'b0;
        @(negedge Clk);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 300) begin
            @(negedge Clk);
            k++;
        end
        check(tag, busy, 0);
    endtask

    task automatic wait_start_id(input string tag, input int id);
        int k = 0;
        while (!(draw_start && draw_img_id == id[2:0]) && k < 300) begin
            @(negedge Clk);
            k++;
        end
        check(tag, draw_start, 1);
    endtask

    task automatic do_reset();
        Reset_N = 1'b0;
        sb.delete();
        for (int i = 0; i < N; i++) shadow[i] = 24'd0;
        repeat (2) @(negedge Clk);
        Reset_N = 1'b1;
    endtask

    // Engine model: Done two cycles after Start, held hold_cycles after Start falls
    initial begin
        forever begin
            @(posedge Clk);
            #1;
            if (!Reset_N) begin
                draw_done = 1'b0;
                ecnt = 0;
            end else if (!draw_done) begin
                if (draw_start) begin
                    if (ecnt >= 2) begin
                        draw_done = 1'b1;
                        ecnt = 0;
                    end else ecnt++;
                end
            end else if (!draw_start) begin
                if (ecnt >= hold_cycles) begin
                    draw_done = 1'b0;
                    ecnt = 0;
                end else ecnt++;
            end
        end
    end

    // Scoreboard monitor on Start rising edges
    initial begin
        forever begin
            @(negedge Clk);
            if (draw_start && !prev_start) begin
                starts++;
                check("start_while_done", draw_done, 0);
                if (sb.size() == 0) begin
                    check("unexpected_start", {9'd0, draw_img_id, draw_y, draw_x}, 32'hFFFF_FFFF);
                end else begin
                    exp_cmd = sb.pop_front();
                    check("draw_cmd", {9'd0, draw_img_id, draw_y, draw_x}, {9'd0, exp_cmd});
                end
            end
            prev_start = draw_start;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) shadow[i] = 24'd0;
        repeat (2) @(negedge Clk);
        check("rst_start", draw_start, 0);
        check("rst_even", even_frame, 0);
        check("rst_busy", busy, 0);
        check("rst_frames", frame_count, 0);
        check("rst_overrun", overrun_count, 0);
        Reset_N = 1'b1;
        enable  = 1'b1;
        @(negedge Clk);

        // Two valid entries, swap latency and ordered handshakes
        write_entry(0, 1'b1, 1, 40, 20);
        write_entry(3, 1'b1, 0, 100, 60);
        push_frame();
        vsync = 1'b1;
        @(negedge Clk);
        check("even_1cyc", even_frame, 0);
        vsync = 1'b0;
        @(negedge Clk);
        check("even_2cyc", even_frame, 1);
        wait_idle("t1_idle");
        check("t1_frames", frame_count, 1);
        check("t1_starts", starts, 2);
        check("t1_sb_empty", sb.size(), 0);

        // Engine holds Done after Start falls
        hold_cycles = 5;
        push_frame();
        pulse_vsync();
        wait_idle("t2_idle");
        check("t2_frames", frame_count, 2);
        check("t2_even", even_frame, 0);
        check("t2_starts", starts, 4);
        hold_cycles = 0;

        // Overrun during entry 0 draw
        push_frame();
        pulse_vsync();
        wait_start_id("t3_start0", 1);
        pulse_vsync();
        check("t3_overrun", overrun_count, 1);
        check("t3_even_kept", even_frame, 1);
        wait_idle("t3_idle");
        check("t3_frames", frame_count, 3);
        check("t3_even_after", even_frame, 1);
        push_frame();
        pulse_vsync();
        check("t3_next_swap", even_frame, 0);
        wait_idle("t3_idle2");
        check("t3_frames2", frame_count, 4);

        // Rewrite an entry while it is being drawn
        push_frame();
        pulse_vsync();
        wait_start_id("t5_start3", 0);
        write_entry(3, 1'b1, 0, 200, 60);
        check("t5_x_stable", draw_x, 100);
        wait_idle("t5_idle");
        push_frame();
        pulse_vsync();
        wait_idle("t5_idle2");
        check("t5_frames", frame_count, 6);
        check("t5_sb_empty", sb.size(), 0);

        // Empty table: edge + swap + 16 scan cycles
        do_reset();
        @(negedge Clk);
        starts0 = starts;
        vsync = 1'b1;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
            vsync = 1'b0;
        end while ((busy || n < 2) && n < 100);
        check("t4_busy_len", n, 18);
        check("t4_frames", frame_count, 1);
        check("t4_even", even_frame, 1);
        check("t4_no_start", starts, starts0);

        // Asynchronous reset mid-draw
        write_entry(0, 1'b1, 1, 40, 20);
        write_entry(3, 1'b1, 0, 100, 60);
        push_frame();
        pulse_vsync();
        wait_start_id("t6_start0", 1);
        pulse_vsync();
        check("t6_overrun", overrun_count, 1);
        wait_start_id("t6_start3", 0);
        #2;
        Reset_N = 1'b0;
        sb.delete();
        for (int i = 0; i < N; i++) shadow[i] = 24'd0;
        #1;
        check("t6_start_drop", draw_start, 0);
        check("t6_even", even_frame, 0);
        check("t6_frames", frame_count, 0);
        check("t6_overrun0", overrun_count, 0);
        check("t6_busy", busy, 0);
        @(negedge Clk);
        @(negedge Clk);
        Reset_N = 1'b1;
        @(negedge Clk);
        starts0 = starts;
        pulse_vsync();
        wait_idle("t6_idle");
        check("t6_tbl_cleared", starts, starts0);
        check("t6_frames_after", frame_count, 1);
        check("final_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
